pass_char_feeder: RTL and testbench

PASS_CHAR_FEEDER -- requirements
Module: pass_char_feeder

---
 rtl/pass_pkg.sv | 19 +
 rtl/char_buf.sv | 28 ++
 rtl/pass_char_feeder.sv | 133 +++++++++++++
 tb/tb_pass_char_feeder.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/pass_pkg.sv
// Purpose : shared defaults and FSM encoding for the password character feeder.
// Latency : n/a (types and constants only).
// Backpressure : n/a.
package pass_pkg;

  localparam int         MAX_LEN_DEFAULT   = 16;
  localparam logic [7:0] TERM_CHAR_DEFAULT = 8'h0D;

  // Count, read index and length share this width; it holds 0..16 without wrapping.
  localparam int IDX_W = 5;

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_DRAIN   = 2'd1,
    ST_DONE    = 2'd2,
    ST_DISCARD = 2'd3
  } state_e;

endpackage

// File: rtl/char_buf.sv
// Purpose : DEPTH x 8 character store, one synchronous write port, one combinational read port.
// Latency : write lands on the clock edge; read data follows rd_idx in the same cycle.
// Backpressure : none; the owner only writes and reads legal indices.
// Ports   : clock; wr_en/wr_idx/wr_data write port; rd_idx/rd_data read port.
module char_buf #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clock,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_idx,
  input  logic [7:0]    wr_data,
  input  logic [AW-1:0] rd_idx,
  output logic [7:0]    rd_data
);

  // Data storage carries no reset: stale bytes are never read before being rewritten.
  logic [7:0] mem_q [DEPTH];

  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem_q[wr_idx] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_idx];

endmodule

// File: rtl/pass_char_feeder.sv
// Purpose : buffers one password (up to MAX_LEN chars, terminated by TERM_CHAR) and replays it to a checker.
// Latency : first character is offered one cycle after the terminator handshake.
// Backpressure : in_ready drops while replaying; replay advances only when out_ready=1.
// Ports   : clock/reset (sync, active-low); in_valid/in_data/in_ready upstream;
//           out_ready/en/data_out/last downstream; done/length per-password status; overflow pulse.
module pass_char_feeder
  import pass_pkg::*;
#(
  parameter int         MAX_LEN   = MAX_LEN_DEFAULT,  // must not exceed 16
  parameter logic [7:0] TERM_CHAR = TERM_CHAR_DEFAULT
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic             in_ready,
  input  logic             out_ready,
  output logic             en,
  output logic [7:0]       data_out,
  output logic             last,
  output logic             done,
  output logic [IDX_W-1:0] length,
  output logic             overflow
);

  localparam int               BUF_AW  = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [IDX_W-1:0] MAX_CNT = IDX_W'(MAX_LEN);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] count_q, count_d;
  logic [IDX_W-1:0] rd_idx_q, rd_idx_d;
  logic [IDX_W-1:0] len_q, len_d;
  logic             ovf_q, ovf_d;
  logic             wr_en;
  logic             is_term;
  logic [7:0]       rd_data;

  assign is_term = (in_data == TERM_CHAR);

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    rd_idx_d = rd_idx_q;
    len_d    = len_q;
    ovf_d    = 1'b0;
    wr_en    = 1'b0;
    in_ready = 1'b0;
    en       = 1'b0;
    last     = 1'b0;
    done     = 1'b0;

    case (state_q)
      ST_COLLECT: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (is_term) begin
            len_d   = count_q;
            // An empty password skips the replay entirely.
            state_d = (count_q != '0) ? ST_DRAIN : ST_DONE;
          end else if (count_q == MAX_CNT) begin
            ovf_d   = 1'b1;
            count_d = '0;
            state_d = ST_DISCARD;
          end else begin
            wr_en   = 1'b1;
            count_d = count_q + IDX_W'(1);
          end
        end
      end

      ST_DISCARD: begin
        in_ready = 1'b1;
        if (in_valid && is_term) begin
          state_d = ST_COLLECT;
        end
      end

      ST_DRAIN: begin
        en = out_ready;
        if (out_ready) begin
          if (rd_idx_q == len_q - IDX_W'(1)) begin
            last    = 1'b1;
            state_d = ST_DONE;
          end else begin
            rd_idx_d = rd_idx_q + IDX_W'(1);
          end
        end
      end

      ST_DONE: begin
        done     = 1'b1;
        count_d  = '0;
        rd_idx_d = '0;
        state_d  = ST_COLLECT;
      end

      default: state_d = ST_COLLECT;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q  <= ST_COLLECT;
      count_q  <= '0;
      rd_idx_q <= '0;
      len_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      rd_idx_q <= rd_idx_d;
      len_q    <= len_d;
      ovf_q    <= ovf_d;
    end
  end

  char_buf #(
    .DEPTH (MAX_LEN),
    .AW    (BUF_AW)
  ) u_char_buf (
    .clock   (clock),
    .wr_en   (wr_en),
    .wr_idx  (count_q[BUF_AW-1:0]),
    .wr_data (in_data),
    .rd_idx  (rd_idx_q[BUF_AW-1:0]),
    .rd_data (rd_data)
  );

  assign data_out = en ? rd_data : 8'h00;
  assign length   = len_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_pass_char_feeder.sv
// Purpose : directed self-checking bench for pass_char_feeder.
// Latency : inputs driven 1 time unit after each rising edge, outputs sampled 1 unit later.
// Backpressure : out_ready is driven explicitly per scenario.
module tb_pass_char_feeder;

  logic       clock = 1'b0;
  logic       reset;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       out_ready;
  logic       en;
  logic [7:0] data_out;
  logic       last;
  logic       done;
  logic [4:0] length;
  logic       overflow;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  pass_char_feeder dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_ready (out_ready),
    .en        (en),
    .data_out  (data_out),
    .last      (last),
    .done      (done),
    .length    (length),
    .overflow  (overflow)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; leaves time just past the edge so inputs can be redriven.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // One-cycle handshake of a character; returns just after the accepting edge.
  task automatic send(input logic [7:0] ch);
    in_valid = 1'b1;
    in_data  = ch;
    #1;
    check($sformatf("in_ready_on_send_%02h", ch), in_ready, 1'b1);
    step();
    in_valid = 1'b0;
    in_data  = 8'h00;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic seen_done;
    logic seen_en;

    reset     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b1;
    repeat (3) step();
    #1;
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_en",       en,       1'b0);
    check("rst_last",     last,     1'b0);
    check("rst_done",     done,     1'b0);
    check("rst_overflow", overflow, 1'b0);
    check("rst_length",   length,   5'd0);
    check("rst_data_out", data_out, 8'h00);
    reset = 1'b1;
    step();

    // "abc" with a ready checker.
    send(8'h61); send(8'h62); send(8'h63); send(8'h0D);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("abc_en_%0d", i),       en,       1'b1);
      check($sformatf("abc_data_%0d", i),     data_out, 8'h61 + i);
      check($sformatf("abc_last_%0d", i),     last,     (i == 2));
      check($sformatf("abc_in_ready_%0d", i), in_ready, 1'b0);
      check($sformatf("abc_done_%0d", i),     done,     1'b0);
      step();
    end
    check("abc_done",     done,     1'b1);
    check("abc_length",   length,   5'd3);
    check("abc_done_en",  en,       1'b0);
    check("abc_done_dat", data_out, 8'h00);
    step();
    check("abc_done_once", done,     1'b0);
    check("abc_back_rdy",  in_ready, 1'b1);

    // Empty password: terminator alone goes straight to the done cycle.
    send(8'h0D);
    check("empty_done",   done,   1'b1);
    check("empty_length", length, 5'd0);
    check("empty_en",     en,     1'b0);
    step();
    check("empty_done_once", done, 1'b0);
    check("empty_en_after",  en,   1'b0);

    // Exactly MAX_LEN characters.
    for (int i = 0; i < 16; i++) send(8'h41 + 8'(i));
    send(8'h0D);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("full_en_%0d", i),   en,       1'b1);
      check($sformatf("full_data_%0d", i), data_out, 8'h41 + i);
      check($sformatf("full_last_%0d", i), last,     (i == 15));
      step();
    end
    check("full_done",   done,   1'b1);
    check("full_length", length, 5'd16);
    step();

    // One character too many: overflow, discard until terminator, then recover.
    for (int i = 0; i < 16; i++) send(8'h41 + 8'(i));
    send(8'h51);
    check("ovf_pulse",    overflow, 1'b1);
    check("ovf_en",       en,       1'b0);
    check("ovf_in_ready", in_ready, 1'b1);
    send(8'h52);
    check("ovf_pulse_once", overflow, 1'b0);
    check("ovf_drop_en",    en,       1'b0);
    send(8'h0D);
    check("ovf_term_done",  done,     1'b0);
    check("ovf_term_en",    en,       1'b0);
    check("ovf_term_rdy",   in_ready, 1'b1);
    send(8'h78); send(8'h0D);
    check("ovf_x_en",   en,       1'b1);
    check("ovf_x_data", data_out, 8'h78);
    check("ovf_x_last", last,     1'b1);
    step();
    check("ovf_x_done",   done,   1'b1);
    check("ovf_x_length", length, 5'd1);
    step();

    // "pw" with out_ready pattern 1,0,0,1.
    send(8'h70); send(8'h77); send(8'h0D);
    check("pw_c0_en",   en,       1'b1);
    check("pw_c0_data", data_out, 8'h70);
    check("pw_c0_last", last,     1'b0);
    check("pw_c0_rdy",  in_ready, 1'b0);
    step();
    out_ready = 1'b0;
    for (int i = 1; i < 3; i++) begin
      #1;
      check($sformatf("pw_stall%0d_en", i),   en,       1'b0);
      check($sformatf("pw_stall%0d_data", i), data_out, 8'h00);
      check($sformatf("pw_stall%0d_rdy", i),  in_ready, 1'b0);
      check($sformatf("pw_stall%0d_done", i), done,     1'b0);
      step();
    end
    out_ready = 1'b1;
    #1;
    check("pw_c3_en",   en,       1'b1);
    check("pw_c3_data", data_out, 8'h77);
    check("pw_c3_last", last,     1'b1);
    check("pw_c3_rdy",  in_ready, 1'b0);
    step();
    check("pw_done",   done,   1'b1);
    check("pw_length", length, 5'd2);
    step();

    // Reset on the second replay cycle of "abcd".
    send(8'h61); send(8'h62); send(8'h63); send(8'h64); send(8'h0D);
    check("rd_c0_data", data_out, 8'h61);
    step();
    check("rd_c1_data", data_out, 8'h62);
    reset = 1'b0;
    step();
    reset = 1'b1;
    #1;
    check("rd_en",       en,       1'b0);
    check("rd_in_ready", in_ready, 1'b1);
    check("rd_done",     done,     1'b0);
    check("rd_overflow", overflow, 1'b0);
    check("rd_length",   length,   5'd0);
    seen_done = 1'b0;
    seen_en   = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      seen_done |= done;
      seen_en   |= en;
    end
    check("rd_no_done_later", seen_done, 1'b0);
    check("rd_no_en_later",   seen_en,   1'b0);
    send(8'h7A); send(8'h0D);
    check("rd_z_data", data_out, 8'h7A);
    check("rd_z_last", last,     1'b1);
    step();
    check("rd_z_done",   done,   1'b1);
    check("rd_z_length", length, 5'd1);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
